// File: rtl/dma_apb_master.sv
// dma_apb_master: APB initiator that turns single valid/ready register commands into APB transfers with a pready timeout
module dma_apb_master #(
    parameter int ADDR_BITS = 13,
    parameter int DATA_BITS = 32,
    parameter int TIMEOUT   = 256,
    parameter int CNT_BITS  = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_BITS-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 busy,
    input  logic                 pclken,
    output logic                 psel,
    output logic                 penable,
    output logic [ADDR_BITS-1:0] paddr,
    output logic                 pwrite,
    output logic [DATA_BITS-1:0] pwdata,
    input  logic [DATA_BITS-1:0] prdata,
    input  logic                 pslverr,
    input  logic                 pready
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state;
    logic [CNT_BITS-1:0] cnt;
    logic last_wait;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign last_wait = cnt == CNT_BITS'(TIMEOUT - 1);
    // Transfer sequencer: APB phases advance on pclken edges, the response handshake runs on clk alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    paddr  <= cmd_addr;
                    pwrite <= cmd_write;
                    pwdata <= cmd_write ? cmd_wdata : '0;
                    cnt    <= '0;
                    psel   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: if (pclken) begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: if (pclken) begin
                    if (pready) begin
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (last_wait) begin
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            rsp_valid   <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_apb_master.sv
// tb_dma_apb_master: random and directed APB command traffic against a transaction-level memory/timeout model
module tb_dma_apb_master;
    localparam int AB = 13;
    localparam int DB = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AB-1:0] cmd_addr;
    logic [DB-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [DB-1:0] rsp_rdata;
    logic          pclken, psel, penable, pwrite, pslverr, pready;
    logic [AB-1:0] paddr;
    logic [DB-1:0] pwdata, prdata;

    always #5 clk = ~clk;

    dma_apb_master #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(TO), .CNT_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .pclken(pclken), .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
        .pslverr(pslverr), .pready(pready)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // slave memory (driven by observed APB traffic) and reference memory (driven by the model)
    logic [31:0] slave_mem [64];
    logic [31:0] ref_mem   [64];
    bit          cur_write, err_flag;
    logic [AB-1:0] cur_addr;
    logic [DB-1:0] cur_wdata;
    int waits_left = 0;
    int pen_cnt = 0;
    int psel_cnt = 0;
    int pdiv = 1;
    int div_cnt = 0;

    // APB slave and pclken source, updated away from the active edge
    initial begin
        pclken = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        forever begin
            @(negedge clk);
            div_cnt = (div_cnt + 1) % pdiv;
            pclken  = div_cnt == 0;
            if (psel && penable && pclken) begin
                pen_cnt++;
                check("apb_addr", 32'(paddr), 32'(cur_addr));
                check("apb_write", 32'(pwrite), 32'(cur_write));
                check("apb_wdata", pwdata, cur_write ? cur_wdata : 32'h0);
                if (waits_left > 0) begin
                    waits_left--;
                    pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
                end else begin
                    pready  = 1'b1;
                    pslverr = err_flag;
                    prdata  = cur_write ? $urandom : slave_mem[paddr[5:0]];
                    if (cur_write && !err_flag) slave_mem[paddr[5:0]] = pwdata;
                end
            end else begin
                pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            end
            if (psel) psel_cnt++;
        end
    end

    // one command end to end; rs pulses reset during ACCESS instead of completing it
    task automatic run_cmd(input bit w, input logic [AB-1:0] a, input logic [DB-1:0] d,
                           input int nw, input bit e, input int dv, input bit rs);
        bit exp_to, exp_err;
        logic [31:0] exp_rd;
        int samples, n, cyc;
        exp_to  = nw >= TO;
        samples = exp_to ? TO : nw + 1;
        exp_err = exp_to ? 1'b1 : e;
        exp_rd  = (exp_to || w) ? 32'h0 : ref_mem[a[5:0]];
        if (!rs && !exp_to && w && !e) ref_mem[a[5:0]] = d;
        cur_write = w; cur_addr = a; cur_wdata = d;
        waits_left = nw; err_flag = e; pen_cnt = 0; psel_cnt = 0; pdiv = dv;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        check("cmd_ready_idle", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = AB'($urandom); cmd_wdata = $urandom;
        check("psel_after_accept", 32'(psel), 32'h1);
        if (rs) begin
            n = 0;
            while (!(psel && penable) && n < 100) begin @(negedge clk); n++; end
            check("rst_reach_access", 32'(penable), 32'h1);
            #2 reset = 1'b0;
            #1;
            check("rst_psel", 32'(psel), 32'h0);
            check("rst_penable", 32'(penable), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            @(negedge clk);
            reset = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("rst_no_rsp", 32'(rsp_valid), 32'h0);
            end
            check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
            return;
        end
        cyc = 1;
        while (!rsp_valid && cyc < 3000) begin @(negedge clk); cyc++; end
        check("rsp_valid", 32'(rsp_valid), 32'h1);
        if (dv == 1) begin
            check("latency", 32'(cyc), 32'(2 + samples));
            check("psel_cycles", 32'(psel_cnt), 32'(1 + samples));
        end
        check("penable_samples", 32'(pen_cnt), 32'(samples));
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
        check("resp_psel", 32'({psel, penable}), 32'h0);
        check("resp_cmd_ready", 32'(cmd_ready), 32'h0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("rsp_hold", {rsp_valid, rsp_err, rsp_timeout, 29'h0} ^ rsp_rdata,
              {1'b1, exp_err, exp_to, 29'h0} ^ exp_rd);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'h1);
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin slave_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        repeat (3) @(negedge clk);
        check("reset_psel", 32'({psel, penable, pwrite}), 32'h0);
        check("reset_busy", 32'({busy, rsp_valid, rsp_err, rsp_timeout}), 32'h0);
        check("reset_paddr", 32'(paddr), 32'h0);
        check("reset_pwdata", pwdata, 32'h0);
        check("reset_rdata", rsp_rdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("release_cmd_ready", 32'(cmd_ready), 32'h1);
        run_cmd(1'b1, 13'h010, 32'hA5A5_0001, 0, 1'b0, 1, 1'b0);
        run_cmd(1'b1, 13'h020, 32'h1234_5678, 0, 1'b0, 1, 1'b0);
        run_cmd(1'b0, 13'h020, 32'h0, 3, 1'b0, 1, 1'b0);
        run_cmd(1'b0, 13'h010, 32'h0, 0, 1'b0, 4, 1'b0);
        run_cmd(1'b0, 13'h004, 32'h0, 0, 1'b0, 4, 1'b0);
        run_cmd(1'b1, 13'h008, 32'hDEAD_BEEF, 0, 1'b1, 1, 1'b0);
        run_cmd(1'b0, 13'h008, 32'h0, 1, 1'b0, 1, 1'b0);
        run_cmd(1'b0, 13'h010, 32'h0, 7, 1'b0, 1, 1'b0);
        run_cmd(1'b0, 13'h010, 32'h0, 20, 1'b0, 1, 1'b0);
        run_cmd(1'b1, 13'h00C, 32'h0BAD_F00D, 30, 1'b0, 2, 1'b0);
        run_cmd(1'b0, 13'h010, 32'h0, 100, 1'b0, 1, 1'b1);
        run_cmd(1'b0, 13'h010, 32'h0, 2, 1'b0, 1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            bit w, e;
            int nw;
            w  = 1'($urandom_range(0, 1));
            e  = $urandom_range(0, 7) == 0;
            nw = ($urandom_range(0, 3) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, TO - 1);
            run_cmd(w, AB'($urandom_range(0, 63)), $urandom, nw, e, $urandom_range(1, 4), 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dma_apb_master.md
Name: dma_apb_master

Overview:
- APB initiator that programs the DMA's APB register port (pclken/psel/penable/paddr/pwrite/pwdata/prdata/pslverr/pready).
- Takes single register commands from a local valid/ready command interface (CPU stub, boot sequencer or testbench driver), runs one APB transfer per command and returns read data and status on a response interface.
- APB phases advance only on pclken-qualified clk edges.
- Includes a pready timeout so a hung slave cannot stall the sequencer.

Parameters:
- ADDR_BITS, 13, APB address width (matches the DMA paddr).
- DATA_BITS, 32, APB data width.
- TIMEOUT, 256, number of pclken-qualified ACCESS-phase samples with pready low before the transfer is aborted.
- CNT_BITS, 9, wait-counter width; must satisfy 2^CNT_BITS > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_BITS  register address.
- cmd_wdata  in  DATA_BITS  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_BITS  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr was sampled high, or a timeout occurred.
- rsp_timeout  out  1  transfer was aborted by the timeout.
- busy  out  1  state != IDLE.
- pclken  in  1  APB clock enable from the system.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_BITS  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_BITS  APB write data.
- prdata  in  DATA_BITS  APB read data.
- pslverr  in  1  APB slave error.
- pready  in  1  APB ready.

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, busy = 0.
  - paddr, pwdata, rsp_rdata = 0.
  - Wait counter = 0.
  - cmd_ready = 1 after reset is released.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: register cmd_addr→paddr, cmd_write→pwrite, cmd_wdata→pwdata (pwdata = 0 for reads); clear the counter; go to SETUP.
  - psel rises on the cycle after acceptance.
- SETUP:
  - psel = 1, penable = 0.
  - On the first clk edge with pclken = 1: go to ACCESS and drive penable = 1.
  - Without pclken, hold the state.
- ACCESS:
  - psel = 1, penable = 1; paddr, pwrite and pwdata stay stable.
  - On a clk edge with pclken & pready:
    - capture rsp_rdata = pwrite ? 0 : prdata;
    - rsp_err = pslverr; rsp_timeout = 0;
    - drop psel and penable; go to RESP.
  - On a clk edge with pclken & !pready:
    - counter increments;
    - if counter == TIMEOUT-1 on that edge (i.e. the TIMEOUT-th wait sample), abort: drop psel and penable, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, go to RESP.
  - Edges without pclken do not change state or the counter.
- RESP:
  - rsp_valid = 1; response fields held stable.
  - cmd_ready = 0.
  - On rsp_ready: rsp_valid falls on the next edge; go to IDLE.
- Throughput:
  - One command in flight; no pipelining.
  - With pclken tied high and pready high: command accepted at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3, IDLE at 4 if rsp_ready is high.
- cmd_valid is ignored outside IDLE; the command source holds it until accepted.
- pclken low during RESP has no effect: the response side runs on clk only.
- pready or pslverr during SETUP is ignored.
- Reset asserted mid-transfer: psel and penable drop immediately (asynchronously); no response is generated for the aborted command.
- TIMEOUT = 1: the first pready-low sample aborts the transfer.

Test Plan:
- Write, pclken = 1, pready = 1: cmd addr 0x010, wdata 0xA5A5_0001 → psel high for 2 cycles, penable high for 1 cycle, paddr = 0x010, pwdata = 0xA5A5_0001, pwrite = 1; rsp_valid 3 cycles after acceptance with rsp_err = 0 and rsp_rdata = 0.
- Read with 3 wait states (pready low for 3 pclken samples), prdata = 0x1234_5678 → rsp_rdata = 0x1234_5678, rsp_err = 0, penable high for 4 pclken samples.
- pclken asserted every 4th clk, read of 0x004 with pready = 1 → SETUP and ACCESS each span 4 clk cycles; APB signals stay stable between enables; response is correct.
- pslverr = 1 on a write completion → rsp_err = 1, rsp_timeout = 0; the next command proceeds normally.
- pready stuck low, TIMEOUT = 8 → psel and penable drop after the 8th wait sample; rsp_err = 1, rsp_timeout = 1; busy returns to 0 after rsp_ready.
- reset pulsed low during ACCESS → psel, penable and busy are 0 immediately, rsp_valid stays 0, cmd_ready = 1 after release; a new read completes correctly.
